// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
//   - op-code constants for the 3-bit operation field
//   - FSM state encoding
//   - is_shift_op(): true for the multi-cycle ops (SHL/SHR/ROL/ROR/ASR)
package shift_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: computes the word after one 1-bit step of op.
// Ports:
//   op    operation code (non-shift codes pass din through)
//   din   current register word
//   si    serial fill bit for SHL/SHR
//   nxt   word after the step
//   so    bit that leaves the word on this step (0 for non-shift codes)
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             si,
    output logic [WIDTH-1:0] nxt,
    output logic             so
);

    always_comb begin
        nxt = din;
        so  = 1'b0;
        case (op)
            OP_SHL: begin
                nxt = {din[WIDTH-2:0], si};
                so  = din[WIDTH-1];
            end
            OP_SHR: begin
                nxt = {si, din[WIDTH-1:1]};
                so  = din[0];
            end
            OP_ROL: begin
                nxt = {din[WIDTH-2:0], din[WIDTH-1]};
                so  = din[WIDTH-1];
            end
            OP_ROR: begin
                nxt = {din[0], din[WIDTH-1:1]};
                so  = din[0];
            end
            OP_ASR: begin
                nxt = {din[WIDTH-1], din[WIDTH-1:1]};
                so  = din[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Registered universal shift register with start/busy/done handshake.
// Shift ops move one bit position per clock for min(amt, WIDTH) clocks.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled only while idle
//   op, amt      operation code and shift amount
//   si           serial fill bit, sampled live on every SHL/SHR step
//   din          parallel load data
//   dout         register contents
//   so           last bit shifted/rotated out
//   busy         shift in progress
//   done         one-cycle completion pulse
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic             si,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             so,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             so_q, so_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_nxt;
    logic             step_so;

    // A shift only enters SHIFT when it has at least one step to do.
    logic             accept_shift;
    assign accept_shift = start && is_shift_op(op) && (amt != '0);

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op  (op_q),
        .din (dout_q),
        .si  (si),
        .nxt (step_nxt),
        .so  (step_so)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept_shift) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == AW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the datapath
    always_comb begin
        op_d   = op_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        so_d   = so_q;
        done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (op == OP_LOAD) begin
                        dout_d = din;
                        done_d = 1'b1;
                    end else if (accept_shift) begin
                        op_d  = op;
                        cnt_d = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;
                    end else begin
                        // NOP, reserved, or a shift by zero
                        done_d = 1'b1;
                    end
                end
            end
            StShift: begin
                dout_d = step_nxt;
                so_d   = step_so;
                cnt_d  = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_NOP;
            cnt_q  <= '0;
            dout_q <= '0;
            so_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            so_q   <= so_d;
            done_q <= done_d;
        end
    end

    // Output logic: everything is taken straight from registers
    always_comb begin
        dout = dout_q;
        so   = so_q;
        done = done_q;
        busy = (state_q == StShift);
    end

endmodule
